id_digit_sequencer: RTL

Parametrised student-ID digit sequencer: holds an N-digit ID and steps through it one digit per accepted `iNext`, presenting the raw digit and the digit modulo a compile-time modulus. It supports wrap, one-shot and ping-pong traversal, run-time reloading of the ID, and a saturating step counter. It is the generalised successor to the fixed 8-state ID-mod-3 generator and feeds the display and timer logic.

---
 rtl/id_digit_sequencer.sv | 127 ++++++++++++
 1 files changed

// File: rtl/id_digit_sequencer.sv
// id_digit_sequencer: steps through a stored N-digit ID one digit per accepted
// advance. It presents the raw digit and the digit reduced modulo MOD.
// Traversal can wrap, stop at the last digit (one-shot) or bounce (ping-pong).
module id_digit_sequencer #(
  parameter int NUM_DIGITS = 8,
  parameter int DIGIT_W    = 4,
  parameter int MOD        = 3,
  parameter logic [NUM_DIGITS*DIGIT_W-1:0] INIT_ID = 32'h27812073,
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1,
  localparam int MOD_W = (MOD > 1) ? $clog2(MOD) : 1
) (
  input  logic                          iClk,
  input  logic                          iRst,
  input  logic                          iNext,
  input  logic                          iLoad,
  input  logic [NUM_DIGITS*DIGIT_W-1:0] iID,
  input  logic [1:0]                    iMode,
  output logic [DIGIT_W-1:0]            oDigit,
  output logic [MOD_W-1:0]              oIDmod3,
  output logic [IDX_W-1:0]              oIndex,
  output logic                          oLast,
  output logic                          oDone,
  output logic [15:0]                   oSteps
);

  typedef enum logic [1:0] {
    MODE_WRAP     = 2'd0,
    MODE_ONESHOT  = 2'd1,
    MODE_PINGPONG = 2'd2,
    MODE_RSVD     = 2'd3
  } mode_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

  mode_t                          mode;
  logic [NUM_DIGITS*DIGIT_W-1:0]  store;
  logic [IDX_W-1:0]               idx;
  logic                           dir;
  logic [15:0]                    steps;
  logic [IDX_W-1:0]               idxNext;
  logic                           dirNext;
  logic                           accepted;
  logic [DIGIT_W-1:0]             digit;

  assign mode = mode_t'(iMode);

  // Where an advance would move the index/direction, and whether it counts as a step.
  always_comb begin
    idxNext  = idx;
    dirNext  = dir;
    accepted = 1'b0;
    case (mode)
      MODE_ONESHOT: begin
        dirNext = 1'b0;
        if (idx < LAST_IDX) begin
          idxNext  = idx + 1'b1;
          accepted = 1'b1;
        end
      end
      MODE_PINGPONG: begin
        accepted = 1'b1;
        if (NUM_DIGITS == 1) begin
          idxNext = '0;
          dirNext = 1'b0;
        end else if (!dir) begin
          if (idx == LAST_IDX) begin
            idxNext = LAST_IDX - 1'b1;
            dirNext = 1'b1;
          end else begin
            idxNext = idx + 1'b1;
          end
        end else begin
          if (idx == '0) begin
            idxNext = IDX_W'(1);
            dirNext = 1'b0;
          end else begin
            idxNext = idx - 1'b1;
          end
        end
      end
      default: begin
        accepted = 1'b1;
        dirNext  = 1'b0;
        idxNext  = (idx == LAST_IDX) ? '0 : idx + 1'b1;
      end
    endcase
  end

  // State register: load beats advance; the step counter saturates instead of wrapping.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      store <= INIT_ID;
      idx   <= '0;
      dir   <= 1'b0;
      steps <= '0;
    end else if (iLoad) begin
      store <= iID;
      idx   <= '0;
      dir   <= 1'b0;
      steps <= '0;
    end else if (iNext) begin
      idx <= idxNext;
      dir <= dirNext;
      if (accepted && (steps != 16'hFFFF)) begin
        steps <= steps + 16'd1;
      end
    end
  end

  // Select the current digit; digit 0 sits in the most-significant bits of the store.
  always_comb begin
    digit = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IDX_W'(i)) begin
        digit = store[(NUM_DIGITS - 1 - i)*DIGIT_W +: DIGIT_W];
      end
    end
  end

  assign oDigit  = digit;
  assign oIDmod3 = MOD_W'(32'(digit) % 32'(MOD));
  assign oIndex  = idx;
  assign oLast   = (idx == LAST_IDX);
  assign oDone   = (mode == MODE_ONESHOT) && oLast;
  assign oSteps  = steps;

endmodule
